// File: rtl/rs232in.sv
// rs232in: asynchronous serial receiver, 8N1, LSB first, line idle high.
// Samples the line at mid-bit and hands bytes to a one-entry holding register.
//
// Ports:
//   clock          - sole clock, rising edge
//   reset          - synchronous, active-high
//   serial_in      - asynchronous RS-232 line (idle high)
//   received_data  - byte in the holding register
//   data_valid     - holding register full
//   data_ready     - consumer accepts the byte (pop on data_valid & data_ready)
//   framing_error  - one-cycle pulse: stop bit sampled low
//   overrun        - one-cycle pulse: good byte dropped, holding register full
module rs232in #(
  parameter int unsigned bps       = 0,
  parameter int unsigned frequency = 0,
  // Divisor guarded so an un-overridden instance still elaborates.
  parameter int unsigned period    = (frequency + bps / 2) / ((bps == 0) ? 1 : bps),
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       data_ready,
  output logic [7:0] received_data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(period / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(period - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic             sync1_q, rx_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             ov_q, ov_d;
  logic             pop;
  logic             tick;

  assign pop  = valid_q & data_ready;
  assign tick = (timer_q == '0);

  // Next-state, bit timing and holding-register update
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q & ~pop;
    fe_d      = 1'b0;
    ov_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_q) begin
          timer_d = HALF_LOAD;
          state_d = S_START;
        end
      end

      S_START: begin
        if (!tick) begin
          timer_d = timer_q - CNT_W'(1);
        end else if (rx_q) begin
          state_d = S_IDLE;  // false start: glitch shorter than half a bit
        end else begin
          bit_idx_d = 3'd0;
          timer_d   = FULL_LOAD;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (!tick) begin
          timer_d = timer_q - CNT_W'(1);
        end else begin
          // Right shift so the first (LSB) bit lands in bit 0 after eight samples
          shift_d   = {rx_q, shift_q[7:1]};
          timer_d   = FULL_LOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (!tick) begin
          timer_d = timer_q - CNT_W'(1);
        end else if (rx_q) begin
          state_d = S_IDLE;
          // A same-cycle pop frees the slot, so delivery wins over overrun
          if (!valid_q || pop) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ov_d = 1'b1;
          end
        end else begin
          fe_d    = 1'b1;
          state_d = S_BREAK;
        end
      end

      S_BREAK: begin
        // Stay here while the line is low so a held break yields one error only
        if (rx_q) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, two-flop line synchronizer
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_q      <= 1'b1;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      sync1_q   <= serial_in;
      rx_q      <= sync1_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign received_data = data_q;
  assign data_valid    = valid_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;

endmodule
